// File: rtl/amp3_sample_feeder.sv
// Stereo sample FIFO paced by a fixed-rate tick. Each tick starts one frame on the
// AMP3 Left Justified interface through its enable/idle handshake.
module amp3_sample_feeder #(
  parameter int dataW      = 12,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 2083,
  parameter int CNTW       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [dataW-1:0]         wr_dataR,
  input  logic [dataW-1:0]         wr_dataL,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     run,
  output logic [dataW-1:0]         dataR,
  output logic [dataW-1:0]         dataL,
  output logic                     enable,
  input  logic                     amp_idle,
  output logic [CNTW-1:0]          underrun_cnt,
  output logic [CNTW-1:0]          late_cnt,
  input  logic                     clr_stats
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {ST_WAIT, ST_START, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q;
  logic                   tick;
  logic [2*dataW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]          wrPtr_q, rdPtr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   full_q, empty_q;
  logic                   push, pop;
  logic [dataW-1:0]       dataR_q, dataR_d, dataL_q, dataL_d;
  logic                   enable_q, enable_d;
  logic                   underInc, lateInc;
  logic [CNTW-1:0]        under_q, under_d, late_q, late_d;

  // Divider only runs while streaming is enabled, so ticks restart cleanly from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            div_q <= '0;
    else if (!run)                      div_q <= '0;
    else if (div_q == DW'(SAMPLE_DIV-1)) div_q <= '0;
    else                                div_q <= div_q + 1'b1;
  end

  assign tick = run && (div_q == DW'(SAMPLE_DIV-1));

  // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign push = wr_en && !full_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {wr_dataR, wr_dataL};
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    dataR_d  = dataR_q;
    dataL_d  = dataL_q;
    pop      = 1'b0;
    underInc = 1'b0;
    lateInc  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (tick) begin
          enable_d = 1'b1;
          state_d  = ST_START;
          if (!empty_q) begin
            pop     = 1'b1;
            dataR_d = mem_q[rdPtr_q][2*dataW-1:dataW];
            dataL_d = mem_q[rdPtr_q][dataW-1:0];
          end else begin
            underInc = 1'b1;
          end
        end
      end
      ST_START: begin
        lateInc = tick;
        if (!amp_idle) begin
          enable_d = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        lateInc = tick;
        if (amp_idle) state_d = ST_WAIT;
      end
      default: begin
        state_d  = ST_WAIT;
        enable_d = 1'b0;
      end
    endcase
  end

  // Statistics saturate; a clear wins over an increment on the same edge.
  always_comb begin
    under_d = under_q;
    late_d  = late_q;
    if (clr_stats) begin
      under_d = '0;
      late_d  = '0;
    end else begin
      if (underInc && (under_q != '1)) under_d = under_q + 1'b1;
      if (lateInc && (late_q != '1))   late_d  = late_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      enable_q <= 1'b0;
      dataR_q  <= '0;
      dataL_q  <= '0;
      under_q  <= '0;
      late_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      dataR_q  <= dataR_d;
      dataL_q  <= dataL_d;
      under_q  <= under_d;
      late_q   <= late_d;
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign level        = level_q;
  assign dataR        = dataR_q;
  assign dataL        = dataL_q;
  assign enable       = enable_q;
  assign underrun_cnt = under_q;
  assign late_cnt     = late_q;

endmodule

// File: tb/tb_amp3_sample_feeder.sv
// Directed bench for amp3_sample_feeder with a behavioural model of the AMP3 interface
// handshake; captured frames and status outputs are compared against hand-computed values.
module tb_amp3_sample_feeder;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int SDIV  = 64;
  localparam int CW    = 3;
  localparam int FRAME = 20;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  wr_dataR = '0, wr_dataL = '0;
  logic           wr_en = 1'b0;
  logic           full, empty;
  logic [LW-1:0]  level;
  logic           run = 1'b0;
  logic [DW-1:0]  dataR, dataL;
  logic           enable;
  logic           amp_idle;
  logic [CW-1:0]  underrun_cnt, late_cnt;
  logic           clr_stats = 1'b0;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  logic holdIdle = 1'b0;
  int frameCnt = 0;
  logic [2*DW-1:0] capQ [$];
  int capCyc [$];

  amp3_sample_feeder #(.dataW(DW), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .wr_dataR(wr_dataR), .wr_dataL(wr_dataL), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level), .run(run), .dataR(dataR), .dataL(dataL),
    .enable(enable), .amp_idle(amp_idle), .underrun_cnt(underrun_cnt),
    .late_cnt(late_cnt), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Interface model: latches a frame when enable is seen while idle, then stays busy
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      amp_idle <= 1'b1;
      frameCnt <= 0;
    end else if (amp_idle) begin
      if (enable && !holdIdle) begin
        capQ.push_back({dataR, dataL});
        capCyc.push_back(cycle);
        amp_idle <= 1'b0;
        frameCnt <= FRAME;
      end
    end else begin
      if (frameCnt == 1) amp_idle <= 1'b1;
      frameCnt <= frameCnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] r, input logic [DW-1:0] l);
    @(negedge clk);
    wr_dataR = r;
    wr_dataL = l;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    capQ.delete();
    capCyc.delete();
  endtask

  task automatic waitCaptures(input int n, input int limit, input logic dropRun);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (capQ.size() >= n) break;
    end
    if (dropRun) run = 1'b0;
    if (k == limit) checkOutput("capture_timeout", capQ.size(), n);
  endtask

  task automatic waitIdle();
    repeat (FRAME + 10) @(negedge clk);
  endtask

  // Starts the divider from 0 and lines up push/clear strobes with the first tick edge
  task automatic tickWith(input logic doPush, input logic doClr,
                          input logic [DW-1:0] r, input logic [DW-1:0] l);
    @(negedge clk);
    run = 1'b1;
    repeat (SDIV - 1) @(posedge clk);
    @(negedge clk);
    wr_dataR  = r;
    wr_dataL  = l;
    wr_en     = doPush;
    clr_stats = doClr;
    @(negedge clk);
    wr_en     = 1'b0;
    clr_stats = 1'b0;
    run       = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_level", level, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_dataR", dataR, 0);
    checkOutput("rst_dataL", dataL, 0);
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_underrun", underrun_cnt, 0);
    checkOutput("rst_late", late_cnt, 0);

    $display("[TB] three pairs streamed in order");
    applyStimulus(12'h123, 12'h456);
    applyStimulus(12'h111, 12'h222);
    applyStimulus(12'h333, 12'h444);
    checkOutput("t1_level3", level, 3);
    run = 1'b1;
    waitCaptures(3, 3 * SDIV + 100, 1'b1);
    if (capQ.size() == 3) begin
      checkOutput("t1_cap0", capQ[0], 24'h123456);
      checkOutput("t1_cap1", capQ[1], 24'h111222);
      checkOutput("t1_cap2", capQ[2], 24'h333444);
      checkOutput("t1_period", capCyc[2] - capCyc[1], SDIV);
    end
    waitIdle();
    checkOutput("t1_level0", level, 0);
    checkOutput("t1_underrun", underrun_cnt, 0);

    $display("[TB] overfill with run low");
    capQ.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(DW'(12'h200 + i), DW'(12'h300 + i));
      if (i == DEPTH - 1) begin
        checkOutput("t2_full", full, 1);
        checkOutput("t2_levelD", level, DEPTH);
      end
    end
    checkOutput("t2_level_after_drop", level, DEPTH);
    run = 1'b1;
    waitCaptures(DEPTH, DEPTH * SDIV + 100, 1'b1);
    waitIdle();
    checkOutput("t2_frames", capQ.size(), DEPTH);
    if (capQ.size() == DEPTH) begin
      checkOutput("t2_first", capQ[0], 24'h200300);
      checkOutput("t2_last", capQ[DEPTH-1], 24'h207307);
    end
    checkOutput("t2_empty", empty, 1);
    checkOutput("t2_underrun", underrun_cnt, 0);

    $display("[TB] underrun repeats last sample");
    capQ.delete();
    applyStimulus(12'h0AB, 12'h0CD);
    run = 1'b1;
    waitCaptures(3, 3 * SDIV + 100, 1'b1);
    waitIdle();
    if (capQ.size() == 3) begin
      checkOutput("t3_cap0", capQ[0], 24'h0AB0CD);
      checkOutput("t3_cap2", capQ[2], 24'h0AB0CD);
    end
    checkOutput("t3_underrun", underrun_cnt, 2);

    $display("[TB] late ticks while stuck in START");
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    capQ.delete();
    applyStimulus(12'h5A5, 12'h3C3);
    applyStimulus(12'h0F0, 12'h00F);
    holdIdle = 1'b1;
    run = 1'b1;
    begin
      int k;
      for (k = 0; k < SDIV + 20; k++) begin
        @(negedge clk);
        if (enable) break;
      end
      if (k == SDIV + 20) checkOutput("t4_enable_timeout", enable, 1);
    end
    repeat (2 * SDIV) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_enable", enable, 1);
    checkOutput("t4_dataR", dataR, 12'h5A5);
    checkOutput("t4_dataL", dataL, 12'h3C3);
    checkOutput("t4_late", late_cnt, 2);
    checkOutput("t4_level", level, 1);
    run = 1'b0;
    holdIdle = 1'b0;
    waitCaptures(1, 20, 1'b0);
    waitIdle();
    if (capQ.size() == 1) checkOutput("t4_cap", capQ[0], 24'h5A53C3);

    $display("[TB] simultaneous push and pop");
    pulseReset();
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(DW'(12'h100 + i), 12'h001);
    checkOutput("t5_level_pre", level, DEPTH - 1);
    tickWith(1'b1, 1'b0, 12'h200, 12'h002);
    checkOutput("t5_level_same", level, DEPTH - 1);
    checkOutput("t5_popped", enable, 1);
    waitIdle();
    applyStimulus(12'h201, 12'h003);
    checkOutput("t5_full", full, 1);
    tickWith(1'b1, 1'b0, 12'h2FF, 12'h0FF);
    checkOutput("t5_drop_level", level, DEPTH - 1);
    checkOutput("t5_drop_full", full, 0);
    waitIdle();

    $display("[TB] async reset mid-frame");
    pulseReset();
    for (int i = 0; i < 6; i++) applyStimulus(DW'(12'h700 + i), DW'(12'h7F0 + i));
    run = 1'b1;
    waitCaptures(1, SDIV + 50, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t6_level5", level, 5);
    checkOutput("t6_dataR_pre", dataR, 12'h700);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_level", level, 0);
    checkOutput("t6_empty", empty, 1);
    checkOutput("t6_dataR", dataR, 0);
    checkOutput("t6_dataL", dataL, 0);
    checkOutput("t6_enable", enable, 0);
    @(negedge clk);
    rst = 1'b0;
    capQ.delete();
    capCyc.delete();

    $display("[TB] counter saturation and clear priority");
    run = 1'b1;
    waitCaptures(8, 8 * SDIV + 100, 1'b1);
    waitIdle();
    checkOutput("t6_sat", underrun_cnt, 7);
    tickWith(1'b0, 1'b1, 12'h000, 12'h000);
    checkOutput("t6_clr_enable", enable, 1);
    checkOutput("t6_clr_underrun", underrun_cnt, 0);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
